jtdsp16_cache_ctrl: RTL
=======================

JTDSP16_CACHE_CTRL -- requirements
Module: jtdsp16_cache_ctrl

Interface
REQ-001 SHALL have these ports (name direction width meaning), clock and reset first: clk in 1 system clock; rst in 1 reset; cen in 1 clock enable, driven from cen2.
REQ-002 SHALL have these control inputs: inst_ok in 1 (current instruction retires this cen); do_en in 1 (do instruction decoded); redo_en in 1 (redo decoded); n_field in 4 (loop body length N); k_field in 7 (iteration count K).
REQ-003 SHALL have data input rom_dout in 16 (instruction word being fetched).
REQ-004 SHALL have these outputs: cache_dout out 16 (replayed instruction); up_cache out 1 (decoder takes cache_dout instead of rom_dout); pc_halt out 1 (freeze XAAU PC); irq_mask out 1 (block interrupts); busy out 1; bad_do out 1 (sticky illegal-do flag).
REQ-005 Reset SHALL be synchronous and active-high, on the single clock clk.

Function
REQ-006 SHALL sample all inputs and update all state only on clk rising edges with cen=1.
REQ-007 SHALL implement FSM states IDLE, LOAD and REPLAY.
REQ-008 IDLE + do_en with N in 1..15: latch N and K, clear wr_ptr, go to LOAD.
REQ-009 IDLE + do_en with N=0: stay in IDLE and set bad_do; bad_do clears only on reset.
REQ-010 LOAD: each inst_ok writes rom_dout to mem[wr_ptr] and increments wr_ptr; PC runs normally (pc_halt=0, up_cache=0).
REQ-011 When the Nth word is written: K<=1 goes to IDLE; K>=2 loads iter=K-1, rd_ptr=0 and goes to REPLAY.
REQ-012 REPLAY: up_cache=1, pc_halt=1, cache_dout=mem[rd_ptr] combinationally; each inst_ok increments rd_ptr.
REQ-013 In REPLAY, when inst_ok retires word N-1: rd_ptr wraps to 0 and iter decrements; iter reaching 0 goes to IDLE, and on that same edge pc_halt and up_cache drop.
REQ-014 irq_mask and busy SHALL equal (state != IDLE).
REQ-015 do_en or redo_en while busy SHALL be ignored (no state change, no flag).
REQ-016 K=0 SHALL be treated as K=1.
REQ-017 N SHALL be 4-bit unsigned; iter SHALL be 7-bit and never underflow.
REQ-018 Cache storage SHALL be 15x16 bits; cache contents SHALL persist after the loop ends.
REQ-019 With cen=0, SHALL hold all state and all outputs.

Reset
REQ-020 rst=1 SHALL force IDLE, wr_ptr=rd_ptr=iter=0, N=0, valid=0 and bad_do=0, and make all 1-bit outputs 0.
REQ-021 cache_dout after reset SHALL be don't-care, because up_cache=0.
REQ-022 Reset during LOAD or REPLAY SHALL abort the loop in the same cycle; the cache memory array itself SHALL NOT be cleared.

Configuration
REQ-023 Macro JTDSP16_CACHE_REDO_EN defined: IDLE + redo_en with valid=1 loads iter=K (K=0 treated as 1), rd_ptr=0 and goes straight to REPLAY, reusing the stored N.
REQ-024 valid SHALL be set when a LOAD completes.
REQ-025 IDLE + redo_en with valid=0 SHALL be ignored.
REQ-026 Macro JTDSP16_CACHE_REDO_EN undefined: redo_en SHALL be ignored, and the valid register and its logic SHALL be absent.

Structure
REQ-027 Shared package jtdsp16_pkg SHALL hold the state encoding (IDLE/LOAD/REPLAY), the cache depth constant (15) and the N/K field widths.
REQ-028 SHALL contain one sub-module, jtdsp16_cache_mem: 15x16 storage with synchronous write and asynchronous read.
REQ-029 The FSM and counters SHALL stay in jtdsp16_cache_ctrl.

Verification
REQ-030 do N=3 K=4, words A,B,C with inst_ok every cen: first pass from ROM, then exactly 9 cache words ABCABCABC with up_cache=1; pc_halt falls after the 12th retire.
REQ-031 do N=2 K=1: words pass through ROM only; up_cache never asserts; busy high for exactly 2 retires.
REQ-032 do N=0: stays IDLE; bad_do=1 and held until rst.
REQ-033 Second do_en asserted mid-REPLAY: ignored; original sequence completes unchanged.
REQ-034 rst pulsed on the 5th replayed word of N=3 K=4: next cycle shows IDLE with all outputs 0.
REQ-035 JTDSP16_CACHE_REDO_EN defined, redo K=2 after the REQ-030 loop: 6 words ABCABC from cache. Macro undefined: redo produces no activity.

Source files
------------

// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 instruction cache used by do/redo loops:
// FSM state encoding, cache depth and N/K field widths.
package jtdsp16_pkg;

  localparam int CACHE_DEPTH = 15;
  localparam int N_W         = 4;
  localparam int K_W         = 7;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REPLAY = 2'd2
  } cache_state_t;

  // An iteration count of zero behaves as a single pass.
  function automatic logic [K_W-1:0] k_eff(input logic [K_W-1:0] k);
    return (k == '0) ? K_W'(1) : k;
  endfunction

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// 15x16 loop-body storage: synchronous write, asynchronous read.
// Contents are never cleared, so a finished loop body stays available.
module jtdsp16_cache_mem
  import jtdsp16_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [N_W-1:0]    i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [N_W-1:0]    i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [CACHE_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr < N_W'(CACHE_DEPTH)))
      r_mem[i_waddr] <= i_wdata;
  end

  // Address 15 is unreachable; return zero rather than reading past the array.
  assign o_rdata = (i_raddr < N_W'(CACHE_DEPTH)) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/jtdsp16_cache_ctrl.sv
// DSP16 do/redo loop cache controller: captures N words on the first pass and
// replays them K-1 times with the PC frozen. Define JTDSP16_CACHE_REDO_EN for redo.
module jtdsp16_cache_ctrl
  import jtdsp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              inst_ok,
  input  logic              do_en,
  input  logic              redo_en,
  input  logic [N_W-1:0]    n_field,
  input  logic [K_W-1:0]    k_field,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] cache_dout,
  output logic              up_cache,
  output logic              pc_halt,
  output logic              irq_mask,
  output logic              busy,
  output logic              bad_do
);

  cache_state_t   r_state, w_state_next;
  logic [N_W-1:0] r_n, w_n_next;
  logic [N_W-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [N_W-1:0] r_rd_ptr, w_rd_ptr_next;
  logic [K_W-1:0] r_k, w_k_next;
  logic [K_W-1:0] r_iter, w_iter_next;
  logic           r_bad_do, w_bad_do_next;
  logic           w_load_wr;
  logic           w_we;
  logic           w_redo_go;

`ifdef JTDSP16_CACHE_REDO_EN
  logic r_valid, w_valid_next;
  assign w_redo_go = redo_en & r_valid;
`else
  logic w_unused_redo;
  assign w_unused_redo = redo_en;
  assign w_redo_go     = 1'b0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_n_next      = r_n;
    w_k_next      = r_k;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_iter_next   = r_iter;
    w_bad_do_next = r_bad_do;
    w_load_wr     = 1'b0;
`ifdef JTDSP16_CACHE_REDO_EN
    w_valid_next  = r_valid;
`endif
    case (r_state)
      IDLE: begin
        if (do_en) begin
          if (n_field != '0) begin
            w_n_next      = n_field;
            w_k_next      = k_eff(k_field);
            w_wr_ptr_next = '0;
            w_state_next  = LOAD;
          end else begin
            w_bad_do_next = 1'b1;
          end
        end else if (w_redo_go) begin
          w_iter_next   = k_eff(k_field);
          w_rd_ptr_next = '0;
          w_state_next  = REPLAY;
        end
      end
      LOAD: begin
        if (inst_ok) begin
          w_load_wr     = 1'b1;
          w_wr_ptr_next = r_wr_ptr + N_W'(1);
          if (r_wr_ptr == r_n - N_W'(1)) begin
`ifdef JTDSP16_CACHE_REDO_EN
            w_valid_next = 1'b1;
`endif
            if (r_k <= K_W'(1)) begin
              w_state_next = IDLE;
            end else begin
              w_iter_next   = r_k - K_W'(1);
              w_rd_ptr_next = '0;
              w_state_next  = REPLAY;
            end
          end
        end
      end
      REPLAY: begin
        if (inst_ok) begin
          if (r_rd_ptr == r_n - N_W'(1)) begin
            w_rd_ptr_next = '0;
            // Saturating decrement keeps iter from wrapping on the final pass.
            if (r_iter <= K_W'(1)) begin
              w_iter_next  = '0;
              w_state_next = IDLE;
            end else begin
              w_iter_next = r_iter - K_W'(1);
            end
          end else begin
            w_rd_ptr_next = r_rd_ptr + N_W'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_n      <= '0;
      r_k      <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_iter   <= '0;
      r_bad_do <= 1'b0;
`ifdef JTDSP16_CACHE_REDO_EN
      r_valid  <= 1'b0;
`endif
    end else if (cen) begin
      r_state  <= w_state_next;
      r_n      <= w_n_next;
      r_k      <= w_k_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_iter   <= w_iter_next;
      r_bad_do <= w_bad_do_next;
`ifdef JTDSP16_CACHE_REDO_EN
      r_valid  <= w_valid_next;
`endif
    end
  end

  assign w_we = w_load_wr & cen & ~rst;

  jtdsp16_cache_mem u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (rom_dout),
    .i_raddr (r_rd_ptr),
    .o_rdata (cache_dout)
  );

  assign up_cache = (r_state == REPLAY);
  assign pc_halt  = (r_state == REPLAY);
  assign busy     = (r_state != IDLE);
  assign irq_mask = (r_state != IDLE);
  assign bad_do   = r_bad_do;

endmodule
